// File: rtl/boron_round_key_store_if.sv
// Round-key store bus: master-key load/stream commands plus the streamed
// round-key handshake (rk_valid/rk_ready).
interface boron_round_key_store_if;
   logic [79:0] key_in;
   logic        load;
   logic        start;
   logic        dir;
   logic        busy;
   logic        keys_ready;
   logic        rk_valid;
   logic        rk_ready;
   logic [63:0] rk_data;
   logic [4:0]  rk_idx;
   logic        rk_last;

   modport master (
      output key_in, load, start, dir, rk_ready,
      input  busy, keys_ready, rk_valid, rk_data, rk_idx, rk_last
   );

   modport slave (
      input  key_in, load, start, dir, rk_ready,
      output busy, keys_ready, rk_valid, rk_data, rk_idx, rk_last
   );
endinterface

// File: rtl/boron_round_key_store.sv
// Expands an 80-bit Boron master key into 26 stored round keys and streams them
// forward or in reverse. Define BORON_KS_RANDOM_RD_EN for a random-access read port.
module boron_round_key_store (
   input  logic                   clk,
   input  logic                   rst,
`ifdef BORON_KS_RANDOM_RD_EN
   input  logic [4:0]             rd_addr,
   output logic [63:0]            rd_data,
`endif
   boron_round_key_store_if.slave bus
);

   localparam logic [4:0] LAST_IDX  = 5'd25;
   localparam logic [4:0] LAST_STEP = 5'd24;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY,
      STREAM
   } state_t;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE;
         4'h1: y = 4'h4;
         4'h2: y = 4'hB;
         4'h3: y = 4'h1;
         4'h4: y = 4'h7;
         4'h5: y = 4'h9;
         4'h6: y = 4'hC;
         4'h7: y = 4'hA;
         4'h8: y = 4'hD;
         4'h9: y = 4'h2;
         4'hA: y = 4'h0;
         4'hB: y = 4'hF;
         4'hC: y = 4'h8;
         4'hD: y = 4'h5;
         4'hE: y = 4'h3;
         default: y = 4'h6;
      endcase
      return y;
   endfunction

   // One key-schedule step: rotate left 13, S-box the low nibble, mix in the round number.
   function automatic logic [79:0] upd(input logic [79:0] k, input logic [4:0] r);
      logic [79:0] t;
      t        = {k[66:0], k[79:67]};
      t[3:0]   = sbox(t[3:0]);
      t[63:59] = t[63:59] ^ r;
      return t;
   endfunction

   state_t             state;
   state_t             state_d;
   logic [79:0]        k_reg;
   logic [79:0]        k_next;
   logic [4:0]         cnt;
   logic [25:0][63:0]  slots;
   logic [4:0]         ptr;
   logic [4:0]         ptr_d;
   logic               dir_q;
   logic               dir_d;
   logic               last_d;
   logic               load_acc;
   logic               start_acc;
   logic               handshake;

   logic               busy_q;
   logic               keys_ready_q;
   logic               rk_valid_q;
   logic               rk_last_q;
   logic [63:0]        rk_data_q;
   logic [4:0]         rk_idx_q;

   assign load_acc  = bus.load && ((state == IDLE) || (state == READY));
   assign start_acc = bus.start && !bus.load && (state == READY);
   assign handshake = rk_valid_q && bus.rk_ready;
   assign k_next    = upd(k_reg, cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      dir_d   = dir_q;
      case (state)
         IDLE: begin
            if (load_acc) state_d = EXPAND;
         end
         EXPAND: begin
            if (cnt == LAST_STEP) state_d = READY;
         end
         READY: begin
            if (load_acc) begin
               state_d = EXPAND;
            end else if (start_acc) begin
               state_d = STREAM;
               dir_d   = bus.dir;
               ptr_d   = bus.dir ? LAST_IDX : 5'd0;
            end
         end
         STREAM: begin
            if (handshake) begin
               if (rk_last_q) begin
                  state_d = READY;
               end else begin
                  ptr_d = dir_q ? (ptr - 5'd1) : (ptr + 5'd1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      last_d = dir_d ? (ptr_d == 5'd0) : (ptr_d == LAST_IDX);
   end

   // Slot 0 is written on the load edge itself; each expansion cycle fills slot cnt+1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_reg <= '0;
         cnt   <= '0;
         slots <= '0;
      end else if (load_acc) begin
         k_reg    <= bus.key_in;
         slots[0] <= bus.key_in[63:0];
         cnt      <= '0;
      end else if (state == EXPAND) begin
         k_reg              <= k_next;
         slots[cnt + 5'd1]  <= k_next[63:0];
         cnt                <= cnt + 5'd1;
      end
   end

   // Outputs are registered from the next state so the first beat appears right after start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q       <= 1'b0;
         keys_ready_q <= 1'b0;
         rk_valid_q   <= 1'b0;
         rk_last_q    <= 1'b0;
         rk_data_q    <= '0;
         rk_idx_q     <= '0;
         ptr          <= '0;
         dir_q        <= 1'b0;
      end else begin
         busy_q       <= (state_d == EXPAND);
         keys_ready_q <= (state_d == READY);
         rk_valid_q   <= (state_d == STREAM);
         ptr          <= ptr_d;
         dir_q        <= dir_d;
         if (state_d == STREAM) begin
            rk_data_q <= slots[ptr_d];
            rk_idx_q  <= ptr_d;
            rk_last_q <= last_d;
         end else begin
            rk_data_q <= '0;
            rk_idx_q  <= '0;
            rk_last_q <= 1'b0;
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.keys_ready = keys_ready_q;
   assign bus.rk_valid   = rk_valid_q;
   assign bus.rk_data    = rk_data_q;
   assign bus.rk_idx     = rk_idx_q;
   assign bus.rk_last    = rk_last_q;

`ifdef BORON_KS_RANDOM_RD_EN
   always_comb begin
      rd_data = '0;
      if (rd_addr <= LAST_IDX) rd_data = slots[rd_addr];
   end
`endif

endmodule

// File: tb/tb_boron_round_key_store.sv
// Directed bench for boron_round_key_store: software key-schedule model feeds a
// scoreboard queue that is drained as round keys are handshaken out.
module tb_boron_round_key_store;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  idx;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [3:0]  sbox_tab [0:15] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
   logic [63:0] exp_keys [0:25];
   logic [63:0] got [0:25];
   beat_t       sb_q [$];

   boron_round_key_store_if bus();

`ifdef BORON_KS_RANDOM_RD_EN
   logic [4:0]  rd_addr = '0;
   logic [63:0] rd_data;
`endif

   boron_round_key_store dut (
      .clk     (clk),
      .rst     (rst),
`ifdef BORON_KS_RANDOM_RD_EN
      .rd_addr (rd_addr),
      .rd_data (rd_data),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] model_upd(input logic [79:0] k, input logic [4:0] r);
      logic [79:0] t;
      t        = (k << 13) | (k >> 67);
      t[3:0]   = sbox_tab[t[3:0]];
      t        = t ^ (80'(r) << 59);
      return t;
   endfunction

   task automatic expand_model(input logic [79:0] key);
      logic [79:0] k;
      k = key;
      exp_keys[0] = key[63:0];
      for (int r = 0; r < 25; r++) begin
         k = model_upd(k, r[4:0]);
         exp_keys[r + 1] = k[63:0];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a master key and time the expansion; optionally pulse start mid-expansion or with load.
   task automatic loadKey(input logic [79:0] key, input int start_at, input bit also_start);
      int n;
      expand_model(key);
      bus.key_in = key;
      bus.load   = 1'b1;
      bus.start  = also_start;
      bus.dir    = 1'b0;
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      n = 1;
      checkOutput("busy_first", bus.busy, 1);
      checkOutput("ready_low", bus.keys_ready, 0);
      checkOutput("no_valid_exp", bus.rk_valid, 0);
      while (!bus.keys_ready && n < 100) begin
         bus.start = (n == start_at);
         tick();
         n++;
         if (n == 25) checkOutput("busy_last", bus.busy, 1);
      end
      bus.start = 1'b0;
      checkOutput("ready_latency", n, 26);
      checkOutput("busy_done", bus.busy, 0);
   endtask

   task automatic applyStimulus(input logic d, input bit rand_ready, input bit inject_load);
      beat_t exp;
      beat_t held;
      bit    stalled;
      bit    rdy;
      int    beats;
      int    cyc;
      for (int i = 0; i < 26; i++) begin
         exp.idx  = d ? 5'(25 - i) : 5'(i);
         exp.data = exp_keys[exp.idx];
         exp.last = (i == 25);
         sb_q.push_back(exp);
      end
      bus.dir   = d;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      stalled = 1'b0;
      held    = '0;
      beats   = 0;
      cyc     = 0;
      while (sb_q.size() > 0 && cyc < 300) begin
         checkOutput("rk_valid", bus.rk_valid, 1);
         if (stalled) begin
            checkOutput("hold_data", bus.rk_data, held.data);
            checkOutput("hold_idx", bus.rk_idx, held.idx);
            checkOutput("hold_last", bus.rk_last, held.last);
         end
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.load   = inject_load && (beats == 5);
         bus.key_in = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
         bus.dir    = (inject_load && beats >= 5) ? ~d : d;
         if (rdy) begin
            exp = sb_q.pop_front();
            checkOutput("rk_data", bus.rk_data, exp.data);
            checkOutput("rk_idx", bus.rk_idx, exp.idx);
            checkOutput("rk_last", bus.rk_last, exp.last);
            got[exp.idx] = bus.rk_data;
            beats++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = '{bus.rk_data, bus.rk_idx, bus.rk_last};
         end
         bus.rk_ready = rdy;
         tick();
         cyc++;
      end
      bus.rk_ready = 1'b0;
      bus.load     = 1'b0;
      if (sb_q.size() != 0) checkOutput("stream_timeout", sb_q.size(), 0);
      sb_q.delete();
      checkOutput("end_valid", bus.rk_valid, 0);
      checkOutput("end_keys_ready", bus.keys_ready, 1);
   endtask

   initial begin
      bus.key_in   = '0;
      bus.load     = 1'b0;
      bus.start    = 1'b0;
      bus.dir      = 1'b0;
      bus.rk_ready = 1'b0;

      repeat (3) tick();
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_keys_ready", bus.keys_ready, 0);
      checkOutput("rst_rk_valid", bus.rk_valid, 0);
      checkOutput("rst_rk_last", bus.rk_last, 0);
      checkOutput("rst_rk_data", bus.rk_data, 0);
      checkOutput("rst_rk_idx", bus.rk_idx, 0);
      rst = 1'b1;
      tick();

      $display("[TB] zero key expansion and reverse stream");
      loadKey(80'h0, 0, 1'b0);
`ifdef BORON_KS_RANDOM_RD_EN
      rd_addr = 5'd1;
      #1 checkOutput("rd_slot1", rd_data, 64'h000000000000000E);
      rd_addr = 5'd2;
      #1 checkOutput("rd_slot2", rd_data, 64'h080000000001C00E);
      rd_addr = 5'd30;
      #1 checkOutput("rd_out_of_range", rd_data, 0);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("zero_slot2", got[2], 64'h080000000001C00E);
      checkOutput("zero_slot1", got[1], 64'h000000000000000E);
      checkOutput("zero_slot0", got[0], 64'h0000000000000000);

      $display("[TB] start during expansion, then forward stream with stalls");
      loadKey(80'h0123456789ABCDEF0123, 5, 1'b0);
      repeat (3) begin
         tick();
         checkOutput("ignored_start_valid", bus.rk_valid, 0);
         checkOutput("ignored_start_ready", bus.keys_ready, 1);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] load and dir change during stream are ignored");
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] load and start together");
      loadKey(80'hA5A5_0F0F_1234_5678_9ABC, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] reset during expansion");
      bus.key_in = 80'h0123456789ABCDEF0123;
      bus.load   = 1'b1;
      tick();
      bus.load = 1'b0;
      repeat (10) tick();
      #2 rst = 1'b0;
      #1;
      checkOutput("mid_rst_busy", bus.busy, 0);
      checkOutput("mid_rst_keys_ready", bus.keys_ready, 0);
      checkOutput("mid_rst_rk_valid", bus.rk_valid, 0);
      checkOutput("mid_rst_rk_data", bus.rk_data, 0);
`ifdef BORON_KS_RANDOM_RD_EN
      rd_addr = 5'd1;
      #1 checkOutput("mid_rst_rd_cleared", rd_data, 0);
`endif
      tick();
      rst = 1'b1;
      tick();
      checkOutput("after_rst_idle_ready", bus.keys_ready, 0);
      loadKey(80'h0123456789ABCDEF0123, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
